// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: entry field bit offsets and entry width.
// Entry layout, LSB first: valid, we, is_load, ready, dest[REG_AW-1:0].
package reg_scoreboard_pkg;

  localparam int unsigned SB_VALID   = 0;
  localparam int unsigned SB_WE      = 1;
  localparam int unsigned SB_IS_LOAD = 2;
  localparam int unsigned SB_READY   = 3;
  localparam int unsigned SB_DEST    = 4;

  function automatic int unsigned sb_entry_wd(input int unsigned reg_aw);
    return reg_aw + 4;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/issue-side bundle of the register scoreboard.
// master = ID/MEM/WB pipeline side, slave = scoreboard.
interface reg_scoreboard_if #(
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic              issue_we;
  logic [REG_AW-1:0] issue_dest;
  logic              issue_is_load;
  logic              src1_valid;
  logic [REG_AW-1:0] src1_addr;
  logic              src2_valid;
  logic [REG_AW-1:0] src2_addr;
  logic              hazard;
  logic              load_ready;
  logic              retire_valid;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output flush, issue_valid, issue_we, issue_dest, issue_is_load,
           src1_valid, src1_addr, src2_valid, src2_addr, load_ready, retire_valid,
    input  issue_ready, hazard, count, full, empty, err
  );

  modport slave (
    input  flush, issue_valid, issue_we, issue_dest, issue_is_load,
           src1_valid, src1_addr, src2_valid, src2_addr, load_ready, retire_valid,
    output issue_ready, hazard, count, full, empty, err
  );
endinterface

// File: rtl/reg_scoreboard_sb_age_match.sv
// sb_age_match: finds the youngest in-flight writer of one source register and
// reports whether that writer is a load whose data is not yet forwardable.
module sb_age_match
  import reg_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5,
  parameter int EW     = REG_AW + 4,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][EW-1:0] entries,
  input  logic [PW-1:0]            head,
  input  logic                     src_valid,
  input  logic [REG_AW-1:0]        src_addr,
  output logic                     hit_hazard
);

  logic          match_found;
  logic          match_load;
  logic          match_ready;
  logic [PW-1:0] idx;
  logic [EW-1:0] ent;

  // Valid entries are contiguous from head, so scanning oldest-first and
  // letting later hits overwrite earlier ones leaves the youngest writer.
  always_comb begin
    match_found = 1'b0;
    match_load  = 1'b0;
    match_ready = 1'b0;
    idx         = '0;
    ent         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      ent = entries[idx];
      if (ent[SB_VALID] && ent[SB_WE] && (ent[SB_DEST +: REG_AW] == src_addr)) begin
        match_found = 1'b1;
        match_load  = ent[SB_IS_LOAD];
        match_ready = ent[SB_READY];
      end
    end
    hit_hazard = src_valid && (src_addr != '0) && match_found && match_load && !match_ready;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order register scoreboard tracking ID->WB in-flight instructions for load-use stalls.
// Optional macro REG_SB_RETIRE_BYPASS_EN: a full scoreboard accepts an issue in the retire cycle.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5
) (
  input logic               clk,
  input logic               resetn,
  reg_scoreboard_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = sb_entry_wd(REG_AW);

  logic [DEPTH-1:0][EW-1:0] entries_reg, entries_next;
  logic [PW-1:0]            head_reg, head_next;
  logic [PW-1:0]            tail_reg, tail_next;
  logic [CW-1:0]            count_reg, count_next;
  logic                     err_reg, err_next;

  logic                     full, empty, issue_ready, issue_fire, retire_fire;
  logic                     lr_found;
  logic [PW-1:0]            lr_idx, lr_pos;
  logic [EW-1:0]            issue_entry;
  logic [1:0]               src_valid, src_hazard;
  logic [1:0][REG_AW-1:0]   src_addr;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

`ifdef REG_SB_RETIRE_BYPASS_EN
  assign issue_ready = ~full | bus.retire_valid;
`else
  assign issue_ready = ~full;
`endif

  assign issue_fire  = bus.issue_valid & issue_ready;
  assign retire_fire = bus.retire_valid & ~empty;

  assign src_valid = {bus.src2_valid, bus.src1_valid};
  assign src_addr  = {bus.src2_addr, bus.src1_addr};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      sb_age_match #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW),
        .EW     (EW),
        .PW     (PW)
      ) u_match (
        .entries    (entries_reg),
        .head       (head_reg),
        .src_valid  (src_valid[gi]),
        .src_addr   (src_addr[gi]),
        .hit_hazard (src_hazard[gi])
      );
    end
  endgenerate

  // Oldest load still waiting on memory data; target of a load_ready pulse.
  always_comb begin
    lr_found = 1'b0;
    lr_idx   = head_reg;
    lr_pos   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lr_pos = head_reg + PW'(k);
      if (!lr_found && entries_reg[lr_pos][SB_VALID] && entries_reg[lr_pos][SB_IS_LOAD]
          && !entries_reg[lr_pos][SB_READY]) begin
        lr_found = 1'b1;
        lr_idx   = lr_pos;
      end
    end
  end

  always_comb begin
    issue_entry                      = '0;
    issue_entry[SB_VALID]            = 1'b1;
    issue_entry[SB_WE]               = bus.issue_we;
    issue_entry[SB_IS_LOAD]          = bus.issue_is_load;
    issue_entry[SB_READY]            = ~bus.issue_is_load;
    issue_entry[SB_DEST +: REG_AW]   = bus.issue_dest;
  end

  // Update order matters: retire clears head before issue writes tail, so a
  // bypassed issue into a full ring lands in the slot just freed.
  always_comb begin
    entries_next = entries_reg;
    head_next    = head_reg;
    tail_next    = tail_reg;
    count_next   = count_reg;
    err_next     = err_reg;
    if (bus.flush) begin
      entries_next = '0;
      head_next    = '0;
      tail_next    = '0;
      count_next   = '0;
    end else begin
      if (bus.retire_valid && empty) begin
        err_next = 1'b1;
      end
      if (bus.load_ready) begin
        if (lr_found) begin
          entries_next[lr_idx][SB_READY] = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
      if (retire_fire) begin
        entries_next[head_reg] = '0;
        head_next              = head_reg + PW'(1);
      end
      if (issue_fire) begin
        entries_next[tail_reg] = issue_entry;
        tail_next              = tail_reg + PW'(1);
      end
      count_next = count_reg + CW'(issue_fire) - CW'(retire_fire);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entries_reg <= '0;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      entries_reg <= entries_next;
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
      err_reg     <= err_next;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.hazard      = |src_hazard;
  assign bus.count       = count_reg;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic
// against a queue-based in-order model. Honours REG_SB_RETIRE_BYPASS_EN.
module tb_reg_scoreboard;

  localparam int DEPTH  = 4;
  localparam int REG_AW = 5;
`ifdef REG_SB_RETIRE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    bit              we;
    logic [REG_AW-1:0] dest;
    bit              is_load;
    bit              ready;
  } ent_t;

  logic clk;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;
  ent_t q[$];
  bit   m_err;

  reg_scoreboard_if #(.DEPTH(DEPTH), .REG_AW(REG_AW)) sb_if ();

  reg_scoreboard #(.DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit model_src_hazard(input bit v, input logic [REG_AW-1:0] a);
    if (!v || a == '0) return 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].we && q[i].dest == a) return q[i].is_load && !q[i].ready;
    end
    return 1'b0;
  endfunction

  function automatic bit model_hazard();
    return model_src_hazard(sb_if.src1_valid, sb_if.src1_addr) ||
           model_src_hazard(sb_if.src2_valid, sb_if.src2_addr);
  endfunction

  function automatic bit model_issue_ready(input bit rv);
    return (q.size() < DEPTH) || (BYPASS && rv);
  endfunction

  // ---------------- drivers ----------------
  task automatic idle();
    sb_if.flush = 0; sb_if.issue_valid = 0; sb_if.issue_we = 0; sb_if.issue_dest = '0;
    sb_if.issue_is_load = 0; sb_if.src1_valid = 0; sb_if.src1_addr = '0;
    sb_if.src2_valid = 0; sb_if.src2_addr = '0; sb_if.load_ready = 0; sb_if.retire_valid = 0;
  endtask

  task automatic set_issue(input bit we, input int dest, input bit ld);
    sb_if.issue_valid = 1; sb_if.issue_we = we;
    sb_if.issue_dest = REG_AW'(dest); sb_if.issue_is_load = ld;
  endtask

  task automatic set_src(input bit v1, input int a1, input bit v2, input int a2);
    sb_if.src1_valid = v1; sb_if.src1_addr = REG_AW'(a1);
    sb_if.src2_valid = v2; sb_if.src2_addr = REG_AW'(a2);
  endtask

  // One clock: captures inputs, advances the model by the rules, returns at posedge+1.
  task automatic tick();
    bit f, iv, we, ld, lr, rv, ir, found;
    logic [REG_AW-1:0] dest;
    ent_t e;
    f = sb_if.flush; iv = sb_if.issue_valid; we = sb_if.issue_we; ld = sb_if.issue_is_load;
    dest = sb_if.issue_dest; lr = sb_if.load_ready; rv = sb_if.retire_valid;
    ir = model_issue_ready(rv);
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (rv && q.size() == 0) m_err = 1'b1;
      if (lr) begin
        found = 1'b0;
        foreach (q[i]) begin
          if (!found && q[i].is_load && !q[i].ready) begin
            q[i].ready = 1'b1;
            found = 1'b1;
          end
        end
        if (!found) m_err = 1'b1;
      end
      if (rv && q.size() > 0) void'(q.pop_front());
      if (iv && ir) begin
        e.we = we; e.dest = dest; e.is_load = ld; e.ready = !ld;
        q.push_back(e);
      end
    end
    #1;
    $display("txn t=%0t flush=%0b issue=%0b(acc=%0b we=%0b rd=%0d ld=%0b) lr=%0b rv=%0b -> count=%0d err=%0b",
             $time, f, iv, iv && ir, we, dest, ld, lr, rv, sb_if.count, sb_if.err);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    idle();
    q.delete(); m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (sb_if.count !== 0) begin $display("FAIL reset_count got=%0d exp=0", sb_if.count); failures++; end
    checks++;
    if (sb_if.empty !== 1'b1) begin $display("FAIL reset_empty got=%0b exp=1", sb_if.empty); failures++; end
    checks++;
    if (sb_if.full !== 1'b0) begin $display("FAIL reset_full got=%0b exp=0", sb_if.full); failures++; end
    checks++;
    if (sb_if.issue_ready !== 1'b1) begin $display("FAIL reset_issue_ready got=%0b exp=1", sb_if.issue_ready); failures++; end
    checks++;
    if (sb_if.hazard !== 1'b0) begin $display("FAIL reset_hazard got=%0b exp=0", sb_if.hazard); failures++; end
    checks++;
    if (sb_if.err !== 1'b0) begin $display("FAIL reset_err got=%0b exp=0", sb_if.err); failures++; end
    checks++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_forwarding();
    idle(); set_issue(1, 5, 0); tick();
    idle(); set_src(1, 5, 0, 0); #1;
    if (sb_if.hazard !== 1'b0) begin $display("FAIL fwd_add_hazard got=%0b exp=0", sb_if.hazard); failures++; end
    checks++;
    if (sb_if.count !== 1) begin $display("FAIL fwd_count1 got=%0d exp=1", sb_if.count); failures++; end
    checks++;
    idle(); set_issue(1, 6, 1); tick();
    idle(); set_src(0, 0, 1, 6); #1;
    if (sb_if.hazard !== 1'b1) begin $display("FAIL load_use_hazard got=%0b exp=1", sb_if.hazard); failures++; end
    checks++;
    sb_if.load_ready = 1; tick();
    sb_if.load_ready = 0; #1;
    if (sb_if.hazard !== 1'b0) begin $display("FAIL load_ready_clear got=%0b exp=0", sb_if.hazard); failures++; end
    checks++;
    idle(); set_issue(1, 7, 1); tick();
    idle(); set_src(1, 7, 0, 0); #1;
    if (sb_if.hazard !== 1'b1) begin $display("FAIL ld_r7_hazard got=%0b exp=1", sb_if.hazard); failures++; end
    checks++;
    idle(); set_issue(1, 7, 0); tick();
    idle(); set_src(1, 7, 1, 0); #1;
    if (sb_if.hazard !== 1'b0) begin $display("FAIL youngest_writer got=%0b exp=0", sb_if.hazard); failures++; end
    checks++;
    if (sb_if.full !== 1'b1) begin $display("FAIL full_flag got=%0b exp=1", sb_if.full); failures++; end
    checks++;
    if (sb_if.issue_ready !== 1'b0) begin $display("FAIL full_issue_ready got=%0b exp=0", sb_if.issue_ready); failures++; end
    checks++;
  endtask

  task automatic test_full_retire();
    idle(); set_issue(1, 9, 1); sb_if.retire_valid = 1; #1;
    if (sb_if.issue_ready !== BYPASS) begin
      $display("FAIL bypass_issue_ready got=%0b exp=%0b", sb_if.issue_ready, BYPASS); failures++;
    end
    checks++;
    tick();
    idle(); #1;
    if (sb_if.count !== (BYPASS ? 4 : 3)) begin
      $display("FAIL full_retire_count got=%0d exp=%0d", sb_if.count, BYPASS ? 4 : 3); failures++;
    end
    checks++;
    set_src(1, 9, 0, 0); #1;
    if (sb_if.hazard !== BYPASS) begin
      $display("FAIL full_retire_hazard got=%0b exp=%0b", sb_if.hazard, BYPASS); failures++;
    end
    checks++;
  endtask

  task automatic test_flush();
    idle(); sb_if.flush = 1; tick();
    idle(); set_issue(1, 10, 1); tick();
    set_issue(1, 11, 1); tick();
    set_issue(1, 12, 0); tick();
    idle(); #1;
    if (sb_if.count !== 3) begin $display("FAIL flush_pre_count got=%0d exp=3", sb_if.count); failures++; end
    checks++;
    sb_if.flush = 1; set_issue(1, 13, 1); tick();
    idle(); set_src(1, 13, 1, 10); #1;
    if (sb_if.count !== 0) begin $display("FAIL flush_count got=%0d exp=0", sb_if.count); failures++; end
    checks++;
    if (sb_if.empty !== 1'b1) begin $display("FAIL flush_empty got=%0b exp=1", sb_if.empty); failures++; end
    checks++;
    if (sb_if.hazard !== 1'b0) begin $display("FAIL flush_no_write got=%0b exp=0", sb_if.hazard); failures++; end
    checks++;
  endtask

  task automatic test_retire_err();
    idle(); sb_if.retire_valid = 1; tick();
    idle(); #1;
    if (sb_if.err !== 1'b1) begin $display("FAIL retire_empty_err got=%0b exp=1", sb_if.err); failures++; end
    checks++;
    sb_if.flush = 1; tick();
    idle(); #1;
    if (sb_if.err !== 1'b1) begin $display("FAIL err_sticky_flush got=%0b exp=1", sb_if.err); failures++; end
    checks++;
  endtask

  task automatic test_reset_mid();
    idle(); set_issue(1, 14, 1); tick();
    idle(); set_issue(1, 15, 0); tick();
    idle(); set_src(1, 14, 0, 0); #1;
    if (sb_if.hazard !== 1'b1) begin $display("FAIL pre_reset_hazard got=%0b exp=1", sb_if.hazard); failures++; end
    checks++;
    #2 resetn = 1'b0;
    q.delete(); m_err = 1'b0;
    #1;
    if (sb_if.count !== 0) begin $display("FAIL midreset_count got=%0d exp=0", sb_if.count); failures++; end
    checks++;
    if (sb_if.hazard !== 1'b0) begin $display("FAIL midreset_hazard got=%0b exp=0", sb_if.hazard); failures++; end
    checks++;
    if (sb_if.err !== 1'b0) begin $display("FAIL midreset_err got=%0b exp=0", sb_if.err); failures++; end
    checks++;
    if (sb_if.empty !== 1'b1 || sb_if.full !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
      $display("FAIL midreset_flags got=%0b%0b%0b exp=100", sb_if.empty, sb_if.full, sb_if.issue_ready);
      failures++;
    end
    checks++;
    @(negedge clk);
    resetn = 1'b1;
    idle();
  endtask

  task automatic test_load_ready_err();
    idle(); set_issue(1, 3, 0); tick();
    idle(); sb_if.load_ready = 1; tick();
    idle(); #1;
    if (sb_if.err !== 1'b1) begin $display("FAIL load_ready_err got=%0b exp=1", sb_if.err); failures++; end
    checks++;
    if (sb_if.count !== 1) begin $display("FAIL load_ready_err_count got=%0d exp=1", sb_if.count); failures++; end
    checks++;
  endtask

  task automatic test_random();
    bit exp_h, exp_r;
    for (int n = 0; n < 300; n++) begin
      idle();
      sb_if.flush = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 60)
        set_issue($urandom_range(0, 99) < 80, $urandom_range(0, 7), $urandom_range(0, 1));
      sb_if.retire_valid = ($urandom_range(0, 99) < 40);
      sb_if.load_ready   = ($urandom_range(0, 99) < 30);
      set_src($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
      #1;
      exp_h = model_hazard();
      exp_r = model_issue_ready(sb_if.retire_valid);
      if (sb_if.hazard !== exp_h) begin
        $display("FAIL rnd_hazard n=%0d got=%0b exp=%0b", n, sb_if.hazard, exp_h); failures++;
      end
      checks++;
      if (sb_if.issue_ready !== exp_r) begin
        $display("FAIL rnd_issue_ready n=%0d got=%0b exp=%0b", n, sb_if.issue_ready, exp_r); failures++;
      end
      checks++;
      tick();
      if (sb_if.count !== q.size()) begin
        $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, sb_if.count, q.size()); failures++;
      end
      checks++;
      if (sb_if.full !== (q.size() == DEPTH) || sb_if.empty !== (q.size() == 0)) begin
        $display("FAIL rnd_full_empty n=%0d got=%0b%0b exp=%0b%0b", n, sb_if.full, sb_if.empty,
                 q.size() == DEPTH, q.size() == 0);
        failures++;
      end
      checks++;
      if (sb_if.err !== m_err) begin
        $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, sb_if.err, m_err); failures++;
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_full_retire();
    test_flush();
    test_retire_err();
    test_reset_mid();
    test_load_ready_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
